// File: rtl/alu_issue_ctrl_pkg.sv
// Shared types and constants for the SLC-3 ALU issue controller.
package alu_issue_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DECODE,
        EXEC,
        WB,
        DONE
    } state_t;

    localparam logic [1:0] ALUK_ADD  = 2'b00;
    localparam logic [1:0] ALUK_AND  = 2'b01;
    localparam logic [1:0] ALUK_NOT  = 2'b10;
    localparam logic [1:0] ALUK_PASS = 2'b11;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_NOT = 4'b1001;

    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Operand/result bus between the issue controller and the combinational ALU.
interface alu_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] SR1;
    logic [DATA_W-1:0] SR2_mux_out;
    logic [1:0]        ALUK;
    logic [DATA_W-1:0] ALU_out;

    modport master (output SR1, output SR2_mux_out, output ALUK, input ALU_out);
    modport slave  (input SR1, input SR2_mux_out, input ALUK, output ALU_out);
endinterface

// File: rtl/alu_issue_ctrl_reg_file.sv
// General-purpose register file: one synchronous write port, two operand reads and a debug read.
module reg_file_8x16 #(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              we,
    input  logic [SEL_W-1:0]  wsel,
    input  logic [DATA_W-1:0] wdata,
    input  logic [SEL_W-1:0]  rsel_a,
    input  logic [SEL_W-1:0]  rsel_b,
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b,
    output logic [DATA_W-1:0] dbg_data
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    // NOTE: this array is reset because software may read any register right after Reset;
    // that forces flops instead of a RAM macro, which is acceptable at eight entries.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we) begin
            regs[wsel] <= wdata;
        end
    end

    assign rdata_a  = regs[rsel_a];
    assign rdata_b  = regs[rsel_b];
    assign dbg_data = regs[dbg_sel];
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: decodes ADD/AND/NOT, feeds the external ALU, writes back and sets NZP.
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter  int DATA_W   = 16,
    parameter  int NUM_REGS = 8,
    localparam int SEL_W    = $clog2(NUM_REGS)
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [15:0]       IR,
    input  logic              reg_ld_en,
    input  logic [SEL_W-1:0]  reg_ld_sel,
    input  logic [DATA_W-1:0] reg_ld_data,
    input  logic [SEL_W-1:0]  dbg_sel,
    output logic [DATA_W-1:0] dbg_data,
    alu_if.master             alu,
    output logic              busy,
    output logic              done,
    output logic              illegal,
    output logic [2:0]        nzp
);
    state_t state, next_state;

    logic [15:0]       ir_q;
    logic [DATA_W-1:0] op_a, op_b, result_q, rd_a, rd_b;
    logic [1:0]        aluk_q, dec_aluk;
    logic [SEL_W-1:0]  dr_q;
    logic              illegal_q, dec_legal;
    logic              we;
    logic [SEL_W-1:0]  wsel;
    logic [DATA_W-1:0] wdata;

    // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of
    // statement order; blocking = is reserved for the combinational processes below.
    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = DECODE;
            DECODE:  next_state = dec_legal ? EXEC : DONE;
            EXEC:    next_state = WB;
            WB:      next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no path leaves one unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        busy            = (state != IDLE);
        done            = (state == DONE);
        illegal         = (state == DONE) && illegal_q;
        alu.ALUK        = ALUK_PASS;
        alu.SR1         = '0;
        alu.SR2_mux_out = '0;
        if (state == EXEC) begin
            alu.ALUK        = aluk_q;
            alu.SR1         = op_a;
            alu.SR2_mux_out = op_b;
        end
    end

    always_comb begin
        dec_aluk  = ALUK_PASS;
        dec_legal = 1'b1;
        case (ir_q[15:12])
            OP_ADD: dec_aluk = ALUK_ADD;
            OP_AND: dec_aluk = ALUK_AND;
            OP_NOT: begin
                dec_aluk  = ALUK_NOT;
                dec_legal = (ir_q[5:0] == 6'h3F);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // Preload is IDLE-only, so it can never collide with the WB write on the shared port.
    always_comb begin
        we    = 1'b0;
        wsel  = reg_ld_sel;
        wdata = reg_ld_data;
        if (state == IDLE && reg_ld_en) begin
            we = 1'b1;
        end else if (state == WB) begin
            we    = 1'b1;
            wsel  = dr_q;
            wdata = result_q;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            ir_q      <= '0;
            op_a      <= '0;
            op_b      <= '0;
            aluk_q    <= ALUK_PASS;
            dr_q      <= '0;
            illegal_q <= 1'b0;
            result_q  <= '0;
            nzp       <= 3'b010;
        end else begin
            case (state)
                IDLE: if (start) ir_q <= IR;
                DECODE: begin
                    op_a      <= rd_a;
                    op_b      <= (ir_q[15:12] == OP_NOT) ? '0 :
                                 ir_q[5] ? DATA_W'(sext5(ir_q[4:0])) : rd_b;
                    aluk_q    <= dec_aluk;
                    dr_q      <= ir_q[11:9];
                    illegal_q <= !dec_legal;
                end
                EXEC: result_q <= alu.ALU_out;
                WB: nzp <= {result_q[DATA_W-1], result_q == '0,
                            !result_q[DATA_W-1] && result_q != '0};
                default: ;
            endcase
        end
    end

    reg_file_8x16 #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_regs (
        .Clk      (Clk),
        .Reset    (Reset),
        .we       (we),
        .wsel     (wsel),
        .wdata    (wdata),
        .rsel_a   (ir_q[8:6]),
        .rsel_b   (ir_q[2:0]),
        .dbg_sel  (dbg_sel),
        .rdata_a  (rd_a),
        .rdata_b  (rd_b),
        .dbg_data (dbg_data)
    );
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed and random instructions against an architectural model.
module tb_alu_issue_ctrl;
    logic        Clk = 1'b0;
    logic        Reset, start, reg_ld_en;
    logic [15:0] IR, reg_ld_data, dbg_data;
    logic [2:0]  reg_ld_sel, dbg_sel, nzp;
    logic        busy, done, illegal;

    int n_checks = 0;
    int n_fails  = 0;

    logic [15:0] mregs [8];
    logic [2:0]  mnzp;

    alu_if #(.DATA_W(16)) bus ();

    alu_issue_ctrl dut (
        .Clk(Clk), .Reset(Reset), .start(start), .IR(IR),
        .reg_ld_en(reg_ld_en), .reg_ld_sel(reg_ld_sel), .reg_ld_data(reg_ld_data),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .alu(bus),
        .busy(busy), .done(done), .illegal(illegal), .nzp(nzp)
    );

    // Stand-in for the existing combinational SLC-3 ALU.
    always_comb begin
        case (bus.ALUK)
            2'b00:   bus.ALU_out = bus.SR1 + bus.SR2_mux_out;
            2'b01:   bus.ALU_out = bus.SR1 & bus.SR2_mux_out;
            2'b10:   bus.ALU_out = ~bus.SR1;
            default: bus.ALU_out = bus.SR1;
        endcase
    end

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural effect of one instruction; returns 1 when it must be rejected.
    function automatic bit model_exec(input logic [15:0] ir);
        logic [15:0] a, b, r;
        a = mregs[ir[8:6]];
        b = ir[5] ? 16'($signed(ir[4:0])) : mregs[ir[2:0]];
        if (ir[15:12] == 4'd1)                              r = a + b;
        else if (ir[15:12] == 4'd5)                         r = a & b;
        else if (ir[15:12] == 4'd9 && ir[5:0] == 6'h3F)     r = ~a;
        else return 1'b1;
        mregs[ir[11:9]] = r;
        mnzp = {r[15], r == 16'd0, !r[15] && r != 16'd0};
        return 1'b0;
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_sel = 3'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), dbg_data, mregs[i]);
        end
    endtask

    task automatic preload(input logic [2:0] sel, input logic [15:0] data);
        @(negedge Clk);
        reg_ld_en = 1'b1; reg_ld_sel = sel; reg_ld_data = data;
        mregs[sel] = data;
        @(negedge Clk);
        reg_ld_en = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [15:0] ir, input bit pre,
                         input logic [2:0] psel, input logic [15:0] pdata);
        int cnt;
        bit ill;
        @(negedge Clk);
        start = 1'b1; IR = ir;
        reg_ld_en = pre; reg_ld_sel = psel; reg_ld_data = pdata;
        if (pre) mregs[psel] = pdata;
        ill = model_exec(ir);
        @(negedge Clk);
        start = 1'b0; reg_ld_en = 1'b0;
        check({tag, "_busy"}, busy, 1);
        cnt = 1;
        while (!done && cnt < 20) begin
            @(negedge Clk);
            cnt++;
        end
        check({tag, "_latency"}, cnt, ill ? 2 : 4);
        check({tag, "_illegal"}, illegal, ill);
        check({tag, "_nzp"}, nzp, mnzp);
        dbg_sel = ir[11:9];
        #1;
        check({tag, "_dr_in_done"}, dbg_data, mregs[ir[11:9]]);
        @(negedge Clk);
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_idle"}, busy, 0);
        check_regs(tag);
    endtask

    initial begin
        int ndone;
        logic [31:0] r;
        logic [3:0]  op;
        logic [5:0]  low6;

        Reset = 1'b1; start = 1'b0; IR = '0;
        reg_ld_en = 1'b0; reg_ld_sel = '0; reg_ld_data = '0; dbg_sel = '0;
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mnzp = 3'b010;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_illegal", illegal, 0);
        check("rst_nzp", nzp, 3'b010);
        check("rst_aluk", bus.ALUK, 2'b11);
        check("rst_sr1", bus.SR1, 0);
        check("rst_sr2", bus.SR2_mux_out, 0);
        check_regs("rst");

        // Directed: add, immediate add/and, NOT, illegal NOT, illegal opcode.
        preload(3'd0, 16'd5);
        preload(3'd1, 16'd7);
        issue("add_reg", 16'h1401, 0, 0, 0);
        check("add_reg_r2", mregs[2], 16'd12);
        issue("add_imm", 16'h1630, 0, 0, 0);
        check("add_imm_r3", mregs[3], 16'hFFF5);
        issue("and_imm", 16'h5620, 0, 0, 0);
        preload(3'd4, 16'h00FF);
        issue("not", 16'h9B3F, 0, 0, 0);
        check("not_r5", mregs[5], 16'hFF00);
        issue("not_bad", 16'h9B3E, 0, 0, 0);
        issue("bad_op", 16'h0000, 0, 0, 0);

        // start and preload during EXEC must both be ignored.
        @(negedge Clk);
        start = 1'b1; IR = 16'h1401;
        void'(model_exec(16'h1401));
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        start = 1'b1; IR = 16'h0000;
        reg_ld_en = 1'b1; reg_ld_sel = 3'd6; reg_ld_data = 16'hBEEF;
        @(negedge Clk);
        start = 1'b0; reg_ld_en = 1'b0;
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) ndone++;
            @(negedge Clk);
        end
        check("busy_start_ignored", ndone, 1);
        check_regs("busy_ld");

        // Reset during EXEC aborts with no write and no done.
        @(negedge Clk);
        start = 1'b1; IR = 16'h1401;
        @(negedge Clk);
        start = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        for (int i = 0; i < 8; i++) mregs[i] = '0;
        mnzp = 3'b010;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_nzp", nzp, 3'b010);
        check_regs("abort");
        Reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 0);

        // Wraparound and preload coinciding with start.
        preload(3'd1, 16'h7FFF);
        issue("wrap", 16'h1261, 0, 0, 0);
        check("wrap_r1", mregs[1], 16'h8000);
        issue("ld_start", 16'h1261, 1, 3'd1, 16'h1234);
        check("ld_start_r1", mregs[1], 16'h1235);

        // Random mix of legal and illegal instructions with occasional co-issued preloads.
        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            case ($urandom_range(0, 9))
                0, 1, 2: op = 4'd1;
                3, 4, 5: op = 4'd5;
                6, 7:    op = 4'd9;
                default: op = 4'($urandom_range(0, 15));
            endcase
            low6 = r[5:0];
            if (op == 4'd9 && $urandom_range(0, 3) != 0) low6 = 6'h3F;
            issue($sformatf("rnd%0d", n), {op, r[11:6], low6}, r[31], r[30:28], r[27:12]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
